seviye_hesaplayici: RTL

- Parametrised, sequential successor to the combinational node-level decoder.
- Accepts a W-bit heap-ordered binary-tree node index (root = 0, children of n are 2n+1 and 2n+2) over a valid/ready handshake.
- Iteratively computes the node's level, floor(log2(index+1)), and its position within that level.
- Sits between the request-queue logic and the floor/level control FSMs; its output handshake supports back-pressure.

---
 rtl/seviye_pkg.sv | 16 +
 rtl/seviye_adim.sv | 20 ++
 rtl/seviye_hesaplayici.sv | 94 +++++++++
 3 files changed

// File: rtl/seviye_pkg.sv
// Shared definitions for the node-level calculator: FSM state codes and a
// width helper usable in parameter expressions.
package seviye_pkg;

    localparam logic [1:0] BOS   = 2'd0;
    localparam logic [1:0] HESAP = 2'd1;
    localparam logic [1:0] SONUC = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/seviye_adim.sv
// One iteration of the level search: halve v, bump the level counter, and
// flag completion once v has no bits above the LSB.
module seviye_adim #(
    parameter int W  = 8,
    parameter int LW = 4
) (
    input  logic [W:0]    v,
    input  logic [LW-1:0] cnt,
    output logic [W:0]    v_sonraki,
    output logic [LW-1:0] cnt_sonraki,
    output logic          bitti
);

    always_comb begin
        v_sonraki   = v >> 1;
        cnt_sonraki = cnt + LW'(1);
        bitti       = (v[W:1] == '0);
    end

endmodule

// File: rtl/seviye_hesaplayici.sv
// Sequential heap-tree node level calculator: level = floor(log2(idx+1)),
// position within the level, with a saturating level output and handshakes.
module seviye_hesaplayici
    import seviye_pkg::*;
#(
    parameter  int W          = 8,
    parameter  int MAX_SEVIYE = W,
    localparam int LW         = clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  dugum,
    input  logic          dugum_gecerli,
    output logic          hazir,
    output logic [LW-1:0] dugumun_seviyesi,
    output logic [W-1:0]  sira,
    output logic          tasma,
    output logic          sonuc_gecerli,
    input  logic          sonuc_hazir
);

    localparam logic [LW-1:0] MAX_L = LW'(MAX_SEVIYE);

    logic [1:0]    durum;
    logic [W-1:0]  idx;
    logic [W:0]    v;
    logic [LW-1:0] cnt;
    logic [W:0]    v_sonraki;
    logic [LW-1:0] cnt_sonraki;
    logic          bitti;
    logic [W:0]    taban;

    seviye_adim #(
        .W  (W),
        .LW (LW)
    ) u_adim (
        .v           (v),
        .cnt         (cnt),
        .v_sonraki   (v_sonraki),
        .cnt_sonraki (cnt_sonraki),
        .bitti       (bitti)
    );

    // First index of level cnt is 2^cnt - 1; W+1 bits so cnt == W still fits.
    always_comb begin
        taban = ((W + 1)'(1) << cnt) - (W + 1)'(1);
    end

    assign hazir = (durum == BOS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum            <= BOS;
            idx              <= '0;
            v                <= '0;
            cnt              <= '0;
            dugumun_seviyesi <= '0;
            sira             <= '0;
            tasma            <= 1'b0;
            sonuc_gecerli    <= 1'b0;
        end else begin
            case (durum)
                BOS: begin
                    if (dugum_gecerli) begin
                        idx   <= dugum;
                        v     <= {1'b0, dugum} + (W + 1)'(1);
                        cnt   <= '0;
                        durum <= HESAP;
                    end
                end
                HESAP: begin
                    if (bitti) begin
                        dugumun_seviyesi <= (cnt > MAX_L) ? MAX_L : cnt;
                        tasma            <= (cnt > MAX_L);
                        sira             <= idx - taban[W-1:0];
                        sonuc_gecerli    <= 1'b1;
                        durum            <= SONUC;
                    end else begin
                        v   <= v_sonraki;
                        cnt <= cnt_sonraki;
                    end
                end
                SONUC: begin
                    if (sonuc_hazir) begin
                        sonuc_gecerli <= 1'b0;
                        durum         <= BOS;
                    end
                end
                default: durum <= BOS;
            endcase
        end
    end

endmodule
